// File: rtl/ex_ic_arbiter_pkg.sv
// Shared types for the execute-to-issue-complete completion path:
// FU count, tag/ROB widths and the completion packet layout.
package ex_ic_arbiter_pkg;

  localparam int unsigned NUM_FU    = 4;
  localparam int unsigned TAG_W     = 6;
  localparam int unsigned ROB_IDX_W = 5;

  typedef logic [TAG_W-1:0]     TAG;
  typedef logic [ROB_IDX_W-1:0] ROB_IDX;

  typedef struct packed {
    logic        valid;
    TAG          dest_tag;
    ROB_IDX      rob_idx;
    logic        take_branch;
    logic [31:0] result;
    logic [31:0] rs2_value;
  } EX_IC_PACKET;

endpackage

// File: rtl/ex_ic_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping from N-1 back to 0. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N);
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_ic_arbiter.sv
// Completion arbiter: one holding slot per FU, round-robin drain of one slot
// per cycle into the registered ex_ic_reg; squash flushes everything in flight.
module ex_ic_arbiter
  import ex_ic_arbiter_pkg::*;
#(
  parameter int unsigned N_FU = NUM_FU
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  EX_IC_PACKET       fu_packet [N_FU],
  output logic [N_FU-1:0]   fu_ready,
  output EX_IC_PACKET       ex_ic_reg
);

  localparam int unsigned PTR_W = $clog2(N_FU);

  logic [N_FU-1:0]  slot_valid;
  EX_IC_PACKET      slot [N_FU];
  logic [PTR_W-1:0] rr_ptr;
  logic [N_FU-1:0]  grant;
  logic [PTR_W-1:0] grant_idx;
  logic             any_grant;

  rr_arbiter #(
    .N     (N_FU),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req       (slot_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A slot being drained this cycle can take a new packet on the same edge.
  always_comb fu_ready = ~slot_valid | grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
      ex_ic_reg  <= '0;
      for (int unsigned i = 0; i < N_FU; i++) slot[i] <= '0;
    end else if (squash) begin
      slot_valid      <= '0;
      ex_ic_reg.valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_FU; i++) begin
        if (fu_packet[i].valid && fu_ready[i]) begin
          slot[i]       <= fu_packet[i];
          slot_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      if (any_grant) begin
        ex_ic_reg       <= slot[grant_idx];
        ex_ic_reg.valid <= 1'b1;
        rr_ptr          <= (grant_idx == PTR_W'(N_FU - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        ex_ic_reg.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_ic_arbiter.sv
// Randomized scoreboard bench for ex_ic_arbiter: a queue-based reference model
// predicts every completion and its edge; a monitor pops and compares.
module tb_ex_ic_arbiter;
  import ex_ic_arbiter_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned NCYC = 2400;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          squash = 1'b0;
  EX_IC_PACKET   fu_packet [N];
  logic [N-1:0]  fu_ready;
  EX_IC_PACKET   ex_ic_reg;

  ex_ic_arbiter #(.N_FU(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .fu_packet (fu_packet),
    .fu_ready  (fu_ready),
    .ex_ic_reg (ex_ic_reg)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned edge_n;
    EX_IC_PACKET pkt;
  } exp_t;

  exp_t        sb_q [$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned edge_cnt = 0;

  // Reference state: what each holding slot contains, plus the FUs' pending work.
  bit          m_full [N];
  EX_IC_PACKET m_slot [N];
  int unsigned m_next;
  bit          pend_valid [N];
  EX_IC_PACKET pend [N];

  function automatic EX_IC_PACKET make_pkt();
    EX_IC_PACKET p;
    p.valid       = 1'b1;
    p.dest_tag    = TAG'($urandom);
    p.rob_idx     = ROB_IDX'($urandom);
    p.take_branch = 1'($urandom);
    p.result      = $urandom;
    p.rs2_value   = $urandom;
    return p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_full[i]     = 1'b0;
      m_slot[i]     = '0;
      pend_valid[i] = 1'b0;
      fu_packet[i]  = '0;
    end
    m_next = 0;
    sb_q.delete();
  endtask

  // Monitor: every valid output must be the oldest prediction, on its predicted edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      edge_cnt++;
      if (ex_ic_reg.valid) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output edge=%0d got tag=%0h rob=%0h res=%h, expected no output",
                   edge_cnt, ex_ic_reg.dest_tag, ex_ic_reg.rob_idx, ex_ic_reg.result);
        end else begin
          e = sb_q.pop_front();
          if (e.edge_n != edge_cnt || ex_ic_reg != e.pkt) begin
            n_fail++;
            $display("FAIL completion edge=%0d got %h, expected %h at edge %0d",
                     edge_cnt, ex_ic_reg, e.pkt, e.edge_n);
          end
        end
      end else if (sb_q.size() > 0 && sb_q[0].edge_n == edge_cnt) begin
        n_checks++;
        n_fail++;
        e = sb_q.pop_front();
        $display("FAIL missing_output edge=%0d got valid=0, expected %h", edge_cnt, e.pkt);
      end
    end
  end

  initial begin
    int          win;
    int          density;
    bit          do_squash;
    logic [N-1:0] exp_ready;

    model_clear();
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);

      // Asynchronous reset dropped in between edges, with work in flight.
      if (cyc == 800 || cyc == 1700) begin
        for (int i = 0; i < N; i++) fu_packet[i] = '0;
        squash = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (ex_ic_reg !== '0) begin
          n_fail++;
          $display("FAIL reset_out got %h, expected 0", ex_ic_reg);
        end
        n_checks++;
        if (fu_ready !== '1) begin
          n_fail++;
          $display("FAIL reset_ready got %b, expected 1111", fu_ready);
        end
        model_clear();
        @(posedge clock);
        #2 reset = 1'b0;
        continue;
      end

      // Winner in the model: the first full slot at or after m_next, circularly.
      win = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_next + k) % N;
        if (win < 0 && m_full[j]) win = j;
      end
      for (int i = 0; i < N; i++) exp_ready[i] = !m_full[i] || (win == i);

      n_checks++;
      if (fu_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL fu_ready cyc=%0d got %b, expected %b", cyc, fu_ready, exp_ready);
      end

      case ((cyc / 200) % 3)
        0:       density = 15;
        1:       density = 50;
        default: density = 100;
      endcase
      if (cyc >= NCYC - 30) density = 0;
      do_squash = (cyc < NCYC - 30) && ($urandom_range(39) == 0);

      for (int i = 0; i < N; i++) begin
        if (!pend_valid[i] && $urandom_range(99) < density) begin
          pend[i]       = make_pkt();
          pend_valid[i] = 1'b1;
        end
        fu_packet[i] = pend_valid[i] ? pend[i] : '0;
      end
      squash = do_squash;

      if (do_squash) begin
        // Handed-off packets are lost; nothing completes; pointer untouched.
        for (int i = 0; i < N; i++) begin
          if (pend_valid[i] && exp_ready[i]) pend_valid[i] = 1'b0;
          m_full[i] = 1'b0;
        end
      end else begin
        if (win >= 0) begin
          exp_t e;
          e.edge_n = edge_cnt + 1;
          e.pkt    = m_slot[win];
          sb_q.push_back(e);
          m_full[win] = 1'b0;
          m_next      = (win + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
          if (pend_valid[i] && exp_ready[i]) begin
            m_slot[i]     = pend[i];
            m_full[i]     = 1'b1;
            pend_valid[i] = 1'b0;
          end
        end
      end
    end

    @(negedge clock);
    squash = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_complete got %0d outstanding completions, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
